// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage store path and the data-memory write port.
// Optional byte forwarding to MEM-stage loads is enabled by defining STORE_FWD_EN.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid_in,
    input  logic [ADDR_WIDTH-1:0]   st_addr_in,
    input  logic [DATA_WIDTH-1:0]   st_data_in,
    input  logic [DATA_WIDTH/8-1:0] st_wea_in,
    output logic                    st_ready_out,
    output logic                    mem_req_valid_out,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr_out,
    output logic [DATA_WIDTH-1:0]   mem_req_data_out,
    output logic [DATA_WIDTH/8-1:0] mem_req_wea_out,
    input  logic                    mem_req_ready_in,
    input  logic                    ld_valid_in,
    input  logic [ADDR_WIDTH-1:0]   ld_addr_in,
    input  logic [DATA_WIDTH/8-1:0] ld_mask_in,
    output logic                    ld_hazard_out,
    output logic [DATA_WIDTH-1:0]   ld_fwd_data_out,
    output logic [DATA_WIDTH/8-1:0] ld_fwd_mask_out,
    output logic                    empty_out
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WAW = ADDR_WIDTH - 2;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [WAW-1:0]        addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [NB-1:0]         wea_q  [DEPTH];

    logic enq, deq;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_match;
    logic any_match;

    // Byte-offset bits are irrelevant at word granularity.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr_in[1:0], ld_addr_in[1:0]};

    assign st_ready_out      = (count_q != CW'(DEPTH));
    assign mem_req_valid_out = (count_q != '0);
    assign empty_out         = (count_q == '0);

    // A store with no enabled bytes is acknowledged but leaves no entry.
    assign enq = st_valid_in && st_ready_out && (st_wea_in != '0);
    assign deq = mem_req_valid_out && mem_req_ready_in;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) tail_d = tail_q + 1'b1;
        if (deq) head_d = head_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr_in[ADDR_WIDTH-1:2];
            data_q[tail_q] <= st_data_in;
            wea_q[tail_q]  <= st_wea_in;
        end
    end

    assign mem_req_addr_out = {addr_q[head_q], 2'b00};
    assign mem_req_data_out = data_q[head_q];
    assign mem_req_wea_out  = wea_q[head_q];

    // An entry is live when its distance from head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] age;
            assign age             = PW'(gi) - head_q;
            assign entry_valid[gi] = ({1'b0, age} < count_q);
            assign entry_match[gi] = entry_valid[gi]
                                  && (addr_q[gi] == ld_addr_in[ADDR_WIDTH-1:2])
                                  && ((wea_q[gi] & ld_mask_in) != '0);
        end
    endgenerate

    assign any_match = |entry_match;

`ifdef STORE_FWD_EN
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [NB-1:0]         fwd_mask;
    logic [PW-1:0]         scan_idx;

    // Walk oldest to youngest so a younger entry overwrites an older one per lane.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        scan_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (entry_match[scan_idx]) begin
                for (int b = 0; b < NB; b++) begin
                    if (wea_q[scan_idx][b] && ld_mask_in[b]) begin
                        fwd_data[b*8 +: 8] = data_q[scan_idx][b*8 +: 8];
                        fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

    assign ld_fwd_data_out = ld_valid_in ? fwd_data : '0;
    assign ld_fwd_mask_out = ld_valid_in ? fwd_mask : '0;
    assign ld_hazard_out   = ld_valid_in && any_match && (fwd_mask != ld_mask_in);
`else
    assign ld_fwd_data_out = '0;
    assign ld_fwd_mask_out = '0;
    assign ld_hazard_out   = ld_valid_in && any_match;
`endif

endmodule
